mem_stage: RTL and testbench

MEM pipeline stage of the RV32 core, between EX and WB. Registers the EX result, performs one data-memory load or store over a req/ack bus, and aligns and extends load data. Detects misaligned accesses and presents the result to WB through the valid/ready/flush pipeline handshake.

---
 rtl/mem_stage.sv | 224 ++++++++++++++++++++++
 tb/tb_mem_stage.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage of the RV32 core, between EX and WB.
// Registers the EX result, performs at most one data-memory load or store over
// a req/ack bus, aligns and extends load data, flags misaligned accesses, and
// hands the result to WB through the valid/ready/flush handshake.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   valid_in / ready_out        EX -> MEM handshake (ready_out is combinational)
//   valid_out / ready_in        MEM -> WB handshake
//   flush_in / flush_out        pipeline flush, forwarded to EX unchanged
//   *_EX                        instruction fields captured from EX
//   *_MEM                       registered instruction fields presented to WB
//   dmem_*                      data-memory bus; request held until dmem_ack
module mem_stage #(
  parameter int unsigned SIDE_W = 89
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              flush_out,
  output logic              valid_out,
  input  logic              ready_in,
  input  logic              flush_in,
  input  logic [31:0]       PC_EX,
  input  logic              rd_wena_EX,
  input  logic [5:0]        rd_addr_EX,
  input  logic [31:0]       rd_data_EX,
  input  logic [31:0]       mem_wdata_EX,
  input  logic              mem_rena_EX,
  input  logic              mem_wena_EX,
  input  logic [2:0]        mem_funct3_EX,
  input  logic              exc_pend_EX,
  input  logic [31:0]       exc_cause_EX,
  input  logic [SIDE_W-1:0] side_EX,
  output logic [31:0]       PC_MEM,
  output logic              rd_wena_MEM,
  output logic [5:0]        rd_addr_MEM,
  output logic [31:0]       rd_data_MEM,
  output logic              exc_pend_MEM,
  output logic [31:0]       exc_cause_MEM,
  output logic [SIDE_W-1:0] side_MEM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [31:0]       dmem_addr,
  output logic [3:0]        dmem_wmask,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack
);

  localparam int unsigned XLEN         = 32;
  localparam int unsigned MASK_W       = 4;
  localparam logic [31:0] CAUSE_LD_MIS = 32'd4;
  localparam logic [31:0] CAUSE_ST_MIS = 32'd6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS   = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              capture_c;
  logic              load_en_c;
  logic              ack_load_c;
  logic              is_load_q;
  logic [2:0]        funct3_q;

  logic              is_store_ex_c;
  logic              is_load_ex_c;
  logic              mem_op_ex_c;
  logic [1:0]        off_ex_c;
  logic              misal_ex_c;
  logic              exc_misal_ex_c;
  logic              go_bus_ex_c;
  logic [MASK_W-1:0] wmask_ex_c;
  logic [XLEN-1:0]   wdata_ex_c;
  logic [XLEN-1:0]   rshift_c;
  logic [XLEN-1:0]   load_data_c;

  // Handshake: capture needs a free slot and no flush in the same cycle
  assign ready_out = (state_q == IDLE) || ((state_q == DONE) && ready_in);
  assign flush_out = flush_in;
  assign capture_c = valid_in && ready_out && !flush_in;

  // EX-side decode; a simultaneous load+store request counts as a store
  assign is_store_ex_c  = mem_wena_EX;
  assign is_load_ex_c   = mem_rena_EX && !mem_wena_EX;
  assign mem_op_ex_c    = is_store_ex_c || is_load_ex_c;
  assign off_ex_c       = rd_data_EX[1:0];
  // funct3[1]=1 covers W and the reserved encodings, all handled as word
  assign misal_ex_c     = ((mem_funct3_EX[1:0] == 2'b01) && off_ex_c[0]) ||
                          (mem_funct3_EX[1] && (off_ex_c != 2'b00));
  assign exc_misal_ex_c = mem_op_ex_c && misal_ex_c;
  assign go_bus_ex_c    = mem_op_ex_c && !misal_ex_c && !exc_pend_EX;

  // Store lane enables and lane-replicated store data
  always_comb begin
    wmask_ex_c = 4'hF;
    wdata_ex_c = mem_wdata_EX;
    case (mem_funct3_EX[1:0])
      2'b00: begin
        wmask_ex_c = 4'b0001 << off_ex_c;
        wdata_ex_c = {4{mem_wdata_EX[7:0]}};
      end
      2'b01: begin
        wmask_ex_c = 4'b0011 << off_ex_c;
        wdata_ex_c = {2{mem_wdata_EX[15:0]}};
      end
      default: begin
        wmask_ex_c = 4'hF;
        wdata_ex_c = mem_wdata_EX;
      end
    endcase
  end

  // Load alignment; rd_data_MEM still holds the effective address while in BUS
  assign rshift_c = dmem_rdata >> {rd_data_MEM[1:0], 3'b000};

  always_comb begin
    load_data_c = rshift_c;
    case (funct3_q[1:0])
      2'b00:   load_data_c = funct3_q[2] ? {24'd0, rshift_c[7:0]}
                                         : {{24{rshift_c[7]}}, rshift_c[7:0]};
      2'b01:   load_data_c = funct3_q[2] ? {16'd0, rshift_c[15:0]}
                                         : {{16{rshift_c[15]}}, rshift_c[15:0]};
      default: load_data_c = rshift_c;
    endcase
  end

  // Next-state logic and per-cycle enables
  always_comb begin
    state_d    = state_q;
    load_en_c  = 1'b0;
    ack_load_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (capture_c) begin
          load_en_c = 1'b1;
          state_d   = go_bus_ex_c ? BUS : DONE;
        end
      end
      BUS: begin
        // An issued access cannot be withdrawn; a flush waits it out in DRAIN
        if (flush_in) begin
          state_d = dmem_ack ? IDLE : DRAIN;
        end else if (dmem_ack) begin
          state_d    = DONE;
          ack_load_c = is_load_q;
        end
      end
      DONE: begin
        if (flush_in) begin
          state_d = IDLE;
        end else if (ready_in) begin
          if (capture_c) begin
            load_en_c = 1'b1;
            state_d   = go_bus_ex_c ? BUS : DONE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        if (dmem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with registered handshake/bus strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      valid_out <= 1'b0;
      dmem_req  <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_out <= (state_d == DONE);
      dmem_req  <= (state_d == BUS) || (state_d == DRAIN);
    end
  end

  // Pipeline register and bus command; loads overwrite rd_data on ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PC_MEM        <= '0;
      rd_wena_MEM   <= 1'b0;
      rd_addr_MEM   <= '0;
      rd_data_MEM   <= '0;
      exc_pend_MEM  <= 1'b0;
      exc_cause_MEM <= '0;
      side_MEM      <= '0;
      is_load_q     <= 1'b0;
      funct3_q      <= '0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wmask    <= '0;
      dmem_wdata    <= '0;
    end else if (load_en_c) begin
      PC_MEM        <= PC_EX;
      rd_wena_MEM   <= rd_wena_EX;
      rd_addr_MEM   <= rd_addr_EX;
      rd_data_MEM   <= rd_data_EX;
      exc_pend_MEM  <= exc_pend_EX || exc_misal_ex_c;
      // A pending EX exception keeps its own cause
      exc_cause_MEM <= exc_pend_EX    ? exc_cause_EX :
                       exc_misal_ex_c ? (is_store_ex_c ? CAUSE_ST_MIS : CAUSE_LD_MIS) :
                                        exc_cause_EX;
      side_MEM      <= side_EX;
      is_load_q     <= is_load_ex_c;
      funct3_q      <= mem_funct3_EX;
      dmem_we       <= is_store_ex_c;
      dmem_addr     <= {rd_data_EX[31:2], 2'b00};
      dmem_wmask    <= is_store_ex_c ? wmask_ex_c : 4'hF;
      dmem_wdata    <= wdata_ex_c;
    end else if (ack_load_c) begin
      rd_data_MEM   <= load_data_c;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage. Directed scenarios from the
// block's behaviour list plus randomized single transactions checked against
// a byte-level reference model.
module tb_mem_stage;

  localparam int unsigned SIDE_W = 89;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              valid_in = 1'b0;
  logic              ready_out;
  logic              flush_out;
  logic              valid_out;
  logic              ready_in = 1'b1;
  logic              flush_in = 1'b0;
  logic [31:0]       PC_EX = '0;
  logic              rd_wena_EX = 1'b0;
  logic [5:0]        rd_addr_EX = '0;
  logic [31:0]       rd_data_EX = '0;
  logic [31:0]       mem_wdata_EX = '0;
  logic              mem_rena_EX = 1'b0;
  logic              mem_wena_EX = 1'b0;
  logic [2:0]        mem_funct3_EX = '0;
  logic              exc_pend_EX = 1'b0;
  logic [31:0]       exc_cause_EX = '0;
  logic [SIDE_W-1:0] side_EX = '0;
  logic [31:0]       PC_MEM;
  logic              rd_wena_MEM;
  logic [5:0]        rd_addr_MEM;
  logic [31:0]       rd_data_MEM;
  logic              exc_pend_MEM;
  logic [31:0]       exc_cause_MEM;
  logic [SIDE_W-1:0] side_MEM;
  logic              dmem_req;
  logic              dmem_we;
  logic [31:0]       dmem_addr;
  logic [3:0]        dmem_wmask;
  logic [31:0]       dmem_wdata;
  logic [31:0]       dmem_rdata = '0;
  logic              dmem_ack = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  mem_stage #(.SIDE_W(SIDE_W)) dut (
    .clk(clk), .reset(reset),
    .valid_in(valid_in), .ready_out(ready_out), .flush_out(flush_out),
    .valid_out(valid_out), .ready_in(ready_in), .flush_in(flush_in),
    .PC_EX(PC_EX), .rd_wena_EX(rd_wena_EX), .rd_addr_EX(rd_addr_EX),
    .rd_data_EX(rd_data_EX), .mem_wdata_EX(mem_wdata_EX),
    .mem_rena_EX(mem_rena_EX), .mem_wena_EX(mem_wena_EX),
    .mem_funct3_EX(mem_funct3_EX), .exc_pend_EX(exc_pend_EX),
    .exc_cause_EX(exc_cause_EX), .side_EX(side_EX),
    .PC_MEM(PC_MEM), .rd_wena_MEM(rd_wena_MEM), .rd_addr_MEM(rd_addr_MEM),
    .rd_data_MEM(rd_data_MEM), .exc_pend_MEM(exc_pend_MEM),
    .exc_cause_MEM(exc_cause_MEM), .side_MEM(side_MEM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]       pc;
    logic              rd_wena;
    logic [5:0]        rd_addr;
    logic [31:0]       rd_data;
    logic [31:0]       wdata;
    logic              rena;
    logic              wena;
    logic [2:0]        f3;
    logic              exc;
    logic [31:0]       cause;
    logic [SIDE_W-1:0] side;
    logic [31:0]       rdata;
  } txn_t;

  typedef struct {
    int                req_cycles;
    bit                stable;
    logic [31:0]       addr;
    logic              we;
    logic [3:0]        mask;
    logic [31:0]       wdata;
    logic              valid;
    logic              valid_gone;
    logic [31:0]       rd_data;
    logic              exc;
    logic [31:0]       cause;
    logic [31:0]       pc;
    logic              rd_wena;
    logic [5:0]        rd_addr;
    logic [SIDE_W-1:0] side;
  } obs_t;

  typedef struct {
    bit          bus;
    bit          store;
    int          req_cycles;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] rd_data;
    logic        exc;
    logic [31:0] cause;
  } exp_t;

  // Reference model: byte-level view of one access
  function automatic exp_t model(input txn_t t, input int dly);
    exp_t   e;
    int     size;
    int     off;
    bit     st;
    bit     ld;
    bit     mis;
    longint v;
    st   = t.wena;
    ld   = t.rena && !t.wena;
    size = (t.f3[1:0] == 2'd0) ? 1 : (t.f3[1:0] == 2'd1) ? 2 : 4;
    off  = int'(t.rd_data % 32'd4);
    mis  = (st || ld) && ((off % size) != 0);
    e.exc   = t.exc || mis;
    e.cause = t.exc ? t.cause : (st ? 32'd6 : 32'd4);
    e.bus   = (st || ld) && !e.exc;
    e.store = st;
    e.req_cycles = e.bus ? dly : 0;
    e.addr  = t.rd_data - 32'(off);
    e.we    = st;
    e.mask  = st ? 4'(((1 << size) - 1) << off) : 4'hF;
    e.wdata = '0;
    for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = t.wdata[8*(i % size) +: 8];
    if (ld && e.bus) begin
      v = longint'(t.rdata >> (8 * off)) & ((64'sd1 <<< (8 * size)) - 1);
      if (!t.f3[2] && size < 4 && v >= (64'sd1 <<< (8 * size - 1)))
        v = v - (64'sd1 <<< (8 * size));
      e.rd_data = 32'(v);
    end else begin
      e.rd_data = t.rd_data;
    end
    return e;
  endfunction

  task automatic set_ex(input txn_t t);
    PC_EX = t.pc; rd_wena_EX = t.rd_wena; rd_addr_EX = t.rd_addr;
    rd_data_EX = t.rd_data; mem_wdata_EX = t.wdata; mem_rena_EX = t.rena;
    mem_wena_EX = t.wena; mem_funct3_EX = t.f3; exc_pend_EX = t.exc;
    exc_cause_EX = t.cause; side_EX = t.side;
  endtask

  function automatic txn_t blank_txn();
    txn_t t;
    t.pc = '0; t.rd_wena = 1'b1; t.rd_addr = 6'd5; t.rd_data = '0; t.wdata = '0;
    t.rena = 1'b0; t.wena = 1'b0; t.f3 = 3'd0; t.exc = 1'b0; t.cause = '0;
    t.side = '0; t.rdata = '0;
    return t;
  endfunction

  // Drive one instruction, act as the memory slave, record what WB sees.
  // Called and returns at posedge+1.
  task automatic drive_txn(input txn_t t, input int dly, output obs_t o);
    int guard;
    o.req_cycles = 0; o.stable = 1'b1; o.addr = '0; o.we = 1'b0;
    o.mask = '0; o.wdata = '0;
    set_ex(t);
    valid_in = 1'b1; ready_in = 1'b1; flush_in = 1'b0;
    @(posedge clk); #1;
    valid_in = 1'b0;
    guard = 0;
    while (dmem_req === 1'b1 && guard < 20) begin
      if (o.req_cycles == 0) begin
        o.addr = dmem_addr; o.we = dmem_we; o.mask = dmem_wmask; o.wdata = dmem_wdata;
      end else if (dmem_addr !== o.addr || dmem_we !== o.we ||
                   dmem_wmask !== o.mask || dmem_wdata !== o.wdata) begin
        o.stable = 1'b0;
      end
      o.req_cycles++;
      if (o.req_cycles >= dly) begin
        dmem_ack = 1'b1; dmem_rdata = t.rdata;
      end
      @(posedge clk); #1;
      dmem_ack = 1'b0; dmem_rdata = $urandom;
      guard++;
    end
    o.valid = valid_out; o.rd_data = rd_data_MEM; o.exc = exc_pend_MEM;
    o.cause = exc_cause_MEM; o.pc = PC_MEM; o.rd_wena = rd_wena_MEM;
    o.rd_addr = rd_addr_MEM; o.side = side_MEM;
    @(posedge clk); #1;
    o.valid_gone = valid_out;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid_out: got %b want 0", valid_out); end
    n_cmp++; if (dmem_req !== 1'b0) begin n_bad++; $display("FAIL reset_dmem_req: got %b want 0", dmem_req); end
    n_cmp++; if (ready_out !== 1'b1) begin n_bad++; $display("FAIL reset_ready_out: got %b want 1", ready_out); end
    n_cmp++;
    if ({PC_MEM, rd_wena_MEM, rd_addr_MEM, rd_data_MEM, exc_pend_MEM, exc_cause_MEM,
         side_MEM, dmem_we, dmem_addr, dmem_wmask, dmem_wdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_regs: got pc=%h rd=%h exc=%b cause=%h addr=%h mask=%b wdata=%h want all 0",
               PC_MEM, rd_data_MEM, exc_pend_MEM, exc_cause_MEM, dmem_addr, dmem_wmask, dmem_wdata);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_lb();
    txn_t t; obs_t o;
    t = blank_txn(); t.pc = 32'h100; t.rd_data = 32'h1003; t.rena = 1'b1;
    t.f3 = 3'b000; t.rdata = 32'h80FF_FF00;
    drive_txn(t, 2, o);
    n_cmp++; if (o.req_cycles != 2) begin n_bad++; $display("FAIL lb_req_cycles: got %0d want 2", o.req_cycles); end
    n_cmp++; if (o.addr !== 32'h1000) begin n_bad++; $display("FAIL lb_addr: got %h want 00001000", o.addr); end
    n_cmp++; if (o.we !== 1'b0 || o.mask !== 4'hF) begin n_bad++; $display("FAIL lb_we_mask: got we=%b mask=%b want 0 1111", o.we, o.mask); end
    n_cmp++; if (o.rd_data !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_rd_data: got %h want ffffff80", o.rd_data); end
    n_cmp++; if (o.valid !== 1'b1 || o.valid_gone !== 1'b0) begin n_bad++; $display("FAIL lb_valid: got %b,%b want 1,0", o.valid, o.valid_gone); end
  endtask

  task automatic test_sh();
    txn_t t; obs_t o;
    t = blank_txn(); t.pc = 32'h104; t.rd_data = 32'h2002; t.wena = 1'b1;
    t.f3 = 3'b001; t.wdata = 32'h0000_ABCD;
    drive_txn(t, 1, o);
    n_cmp++; if (o.req_cycles != 1) begin n_bad++; $display("FAIL sh_req_cycles: got %0d want 1", o.req_cycles); end
    n_cmp++; if (o.we !== 1'b1 || o.mask !== 4'b1100) begin n_bad++; $display("FAIL sh_we_mask: got we=%b mask=%b want 1 1100", o.we, o.mask); end
    n_cmp++; if (o.wdata !== 32'hABCD_ABCD) begin n_bad++; $display("FAIL sh_wdata: got %h want abcdabcd", o.wdata); end
    n_cmp++; if (o.addr !== 32'h2000) begin n_bad++; $display("FAIL sh_addr: got %h want 00002000", o.addr); end
    n_cmp++; if (o.rd_data !== 32'h2002) begin n_bad++; $display("FAIL sh_rd_data: got %h want 00002002", o.rd_data); end
  endtask

  task automatic test_misaligned();
    txn_t t; obs_t o;
    t = blank_txn(); t.rd_data = 32'h3001; t.rena = 1'b1; t.f3 = 3'b010;
    drive_txn(t, 1, o);
    n_cmp++; if (o.req_cycles != 0) begin n_bad++; $display("FAIL lw_mis_req: got %0d want 0", o.req_cycles); end
    n_cmp++; if (o.exc !== 1'b1 || o.cause !== 32'd4) begin n_bad++; $display("FAIL lw_mis_exc: got %b/%0d want 1/4", o.exc, o.cause); end
    n_cmp++; if (o.valid !== 1'b1) begin n_bad++; $display("FAIL lw_mis_valid: got %b want 1", o.valid); end
    t.rena = 1'b0; t.wena = 1'b1;
    drive_txn(t, 1, o);
    n_cmp++; if (o.req_cycles != 0) begin n_bad++; $display("FAIL sw_mis_req: got %0d want 0", o.req_cycles); end
    n_cmp++; if (o.exc !== 1'b1 || o.cause !== 32'd6) begin n_bad++; $display("FAIL sw_mis_exc: got %b/%0d want 1/6", o.exc, o.cause); end
  endtask

  task automatic test_lhu_exc();
    txn_t t; obs_t o;
    t = blank_txn(); t.rd_data = 32'h4002; t.rena = 1'b1; t.f3 = 3'b101;
    t.rdata = 32'h8001_0000;
    drive_txn(t, 1, o);
    n_cmp++; if (o.rd_data !== 32'h0000_8001) begin n_bad++; $display("FAIL lhu_rd_data: got %h want 00008001", o.rd_data); end
    n_cmp++; if (o.exc !== 1'b0) begin n_bad++; $display("FAIL lhu_exc: got %b want 0", o.exc); end
    t.exc = 1'b1; t.cause = 32'd2;
    drive_txn(t, 1, o);
    n_cmp++; if (o.req_cycles != 0) begin n_bad++; $display("FAIL exc_in_req: got %0d want 0", o.req_cycles); end
    n_cmp++; if (o.exc !== 1'b1 || o.cause !== 32'd2) begin n_bad++; $display("FAIL exc_in_cause: got %b/%0d want 1/2", o.exc, o.cause); end
    n_cmp++; if (o.rd_data !== 32'h4002) begin n_bad++; $display("FAIL exc_in_rd_data: got %h want 00004002", o.rd_data); end
  endtask

  task automatic test_back_to_back();
    txn_t t;
    logic [31:0] vals [5];
    logic [31:0] stall_val;
    t = blank_txn();
    for (int i = 0; i < 5; i++) vals[i] = $urandom;
    stall_val = $urandom;
    ready_in = 1'b1;
    t.rd_data = vals[0]; t.pc = 32'h200; set_ex(t); valid_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (valid_out !== 1'b1 || rd_data_MEM !== vals[i] || PC_MEM !== 32'h200 + 32'(4*i)) begin
        n_bad++; $display("FAIL b2b_result%0d: got v=%b rd=%h pc=%h want 1 %h %h", i, valid_out, rd_data_MEM, PC_MEM, vals[i], 32'h200 + 32'(4*i));
      end
      if (i < 4) begin t.rd_data = vals[i+1]; t.pc = 32'h200 + 32'(4*(i+1)); set_ex(t); end
    end
    ready_in = 1'b0; t.rd_data = stall_val; t.pc = 32'h300; set_ex(t);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (ready_out !== 1'b0) begin n_bad++; $display("FAIL stall_ready_out%0d: got %b want 0", i, ready_out); end
      @(posedge clk); #1;
      n_cmp++; if (valid_out !== 1'b1 || rd_data_MEM !== vals[4]) begin
        n_bad++; $display("FAIL stall_frozen%0d: got v=%b rd=%h want 1 %h", i, valid_out, rd_data_MEM, vals[4]);
      end
    end
    ready_in = 1'b1; #1;
    n_cmp++; if (ready_out !== 1'b1) begin n_bad++; $display("FAIL stall_release_ready: got %b want 1", ready_out); end
    @(posedge clk); #1;
    valid_in = 1'b0;
    n_cmp++; if (valid_out !== 1'b1 || rd_data_MEM !== stall_val) begin
      n_bad++; $display("FAIL stall_next: got v=%b rd=%h want 1 %h", valid_out, rd_data_MEM, stall_val);
    end
    @(posedge clk); #1;
    n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: got %b want 0", valid_out); end
  endtask

  task automatic test_flush();
    txn_t t;
    t = blank_txn(); t.rd_data = 32'h5000; t.rena = 1'b1; t.f3 = 3'b010;
    set_ex(t); valid_in = 1'b1; ready_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    n_cmp++; if (dmem_req !== 1'b1) begin n_bad++; $display("FAIL flush_bus_req: got %b want 1", dmem_req); end
    flush_in = 1'b1; #1;
    n_cmp++; if (flush_out !== 1'b1) begin n_bad++; $display("FAIL flush_out: got %b want 1", flush_out); end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      flush_in = 1'b0;
      n_cmp++; if (dmem_req !== 1'b1 || valid_out !== 1'b0 || ready_out !== 1'b0) begin
        n_bad++; $display("FAIL drain%0d: got req=%b v=%b rdy=%b want 1 0 0", k, dmem_req, valid_out, ready_out);
      end
      if (k == 2) begin dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF; end
    end
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    n_cmp++; if (dmem_req !== 1'b0 || valid_out !== 1'b0 || ready_out !== 1'b1) begin
      n_bad++; $display("FAIL drain_end: got req=%b v=%b rdy=%b want 0 0 1", dmem_req, valid_out, ready_out);
    end
    n_cmp++; if (rd_data_MEM !== 32'h5000) begin n_bad++; $display("FAIL drain_discard: got %h want 00005000", rd_data_MEM); end
    @(posedge clk); #1;
    n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL drain_no_result: got %b want 0", valid_out); end
    // Flush in DONE drops the result and blocks a simultaneous capture
    t = blank_txn(); t.rd_data = 32'h6001; t.rena = 1'b1; t.f3 = 3'b001;
    set_ex(t); valid_in = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (valid_out !== 1'b1) begin n_bad++; $display("FAIL done_pre_flush: got %b want 1", valid_out); end
    t = blank_txn(); t.rd_data = 32'h7777; set_ex(t);
    ready_in = 1'b0; flush_in = 1'b1;
    @(posedge clk); #1;
    flush_in = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
    n_cmp++; if (valid_out !== 1'b0 || rd_data_MEM !== 32'h6001) begin
      n_bad++; $display("FAIL done_flush: got v=%b rd=%h want 0 00006001", valid_out, rd_data_MEM);
    end
    @(posedge clk); #1;
    n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL done_flush_idle: got %b want 0", valid_out); end
  endtask

  task automatic test_reset_midbus();
    txn_t t;
    t = blank_txn(); t.rd_data = 32'h8000; t.wena = 1'b1; t.f3 = 3'b010; t.wdata = 32'h1234_5678;
    set_ex(t); valid_in = 1'b1; ready_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    n_cmp++; if (dmem_req !== 1'b1) begin n_bad++; $display("FAIL rst_mid_pre: got %b want 1", dmem_req); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (dmem_req !== 1'b0 || rd_data_MEM !== 32'h0) begin
      n_bad++; $display("FAIL rst_mid_drop: got req=%b rd=%h want 0 0", dmem_req, rd_data_MEM);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    txn_t t; obs_t o; exp_t e;
    int dly;
    int kind;
    for (int n = 0; n < 60; n++) begin
      t = blank_txn();
      kind = int'($urandom_range(0, 3));
      t.rena = (kind == 1 || kind == 3);
      t.wena = (kind == 2 || kind == 3);
      t.f3 = 3'($urandom_range(0, 7));
      t.pc = $urandom; t.rd_wena = 1'($urandom); t.rd_addr = 6'($urandom);
      t.rd_data = $urandom; t.wdata = $urandom; t.rdata = $urandom;
      t.exc = ($urandom_range(0, 5) == 0); t.cause = 32'($urandom_range(0, 15));
      t.side = SIDE_W'({$urandom, $urandom, $urandom});
      dly = int'($urandom_range(1, 3));
      e = model(t, dly);
      drive_txn(t, dly, o);
      n_cmp++; if (o.req_cycles != e.req_cycles) begin n_bad++; $display("FAIL rnd%0d_req: got %0d want %0d", n, o.req_cycles, e.req_cycles); end
      n_cmp++; if (o.valid !== 1'b1 || o.valid_gone !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_valid: got %b,%b want 1,0", n, o.valid, o.valid_gone); end
      n_cmp++; if (o.rd_data !== e.rd_data) begin n_bad++; $display("FAIL rnd%0d_rd_data: got %h want %h (f3=%b addr=%h rdata=%h)", n, o.rd_data, e.rd_data, t.f3, t.rd_data, t.rdata); end
      n_cmp++; if (o.exc !== e.exc || (e.exc && o.cause !== e.cause)) begin n_bad++; $display("FAIL rnd%0d_exc: got %b/%0d want %b/%0d", n, o.exc, o.cause, e.exc, e.cause); end
      n_cmp++; if (o.pc !== t.pc || o.rd_wena !== t.rd_wena || o.rd_addr !== t.rd_addr || o.side !== t.side) begin
        n_bad++; $display("FAIL rnd%0d_fields: got pc=%h we=%b ad=%h want %h %b %h", n, o.pc, o.rd_wena, o.rd_addr, t.pc, t.rd_wena, t.rd_addr);
      end
      if (e.bus) begin
        n_cmp++; if (o.addr !== e.addr || o.we !== e.we || o.mask !== e.mask || !o.stable) begin
          n_bad++; $display("FAIL rnd%0d_bus: got a=%h we=%b m=%b st=%b want %h %b %b 1", n, o.addr, o.we, o.mask, o.stable, e.addr, e.we, e.mask);
        end
        if (e.store) begin
          n_cmp++; if (o.wdata !== e.wdata) begin n_bad++; $display("FAIL rnd%0d_wdata: got %h want %h", n, o.wdata, e.wdata); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lb();
    test_sh();
    test_misaligned();
    test_lhu_exc();
    test_back_to_back();
    test_flush();
    test_reset_midbus();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
